// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder1bit cell reused LSB-first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, busy_q, busy_d, done_q, done_d;
  logic               cout_q, cout_d;
  logic               cell_y, cell_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  FullAdder1bit u_fa (
    .w0   (a_sh_q[0]),
    .w1   (b_sh_q[0]),
    .cin  (carry_q),
    .y    (cell_y),
    .cout (cell_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      RUN: begin
        s_sh_d  = {cell_y, s_sh_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          sum_d   = {cell_y, s_sh_q[WIDTH-1:1]};
          cout_d  = cell_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ cell_co;
`endif
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE gives back-to-back ops
        done_d = 1'b0;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          s_sh_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// 1-bit full adder cell shared by the serial datapath.
module FullAdder1bit (
  input  logic w0,
  input  logic w1,
  input  logic cin,
  output logic y,
  output logic cout
);
  assign y    = w0 ^ w1 ^ cin;
  assign cout = (w0 & w1) | (cin & (w0 ^ w1));
endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder: driver pushes a+b+cin results, monitor pops on done.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk, rst, start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   total = 0;
  int   bad = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   ux, sx;
    ux    = int'(x) + int'(y) + int'(c);
    sx    = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.sum = ux[W-1:0];
    e.co  = ux >= (1 << W);
    e.ov  = (sx > (1 << (W-1)) - 1) || (sx < -(1 << (W-1)));
    return e;
  endfunction

  // Called on a negedge while the DUT is IDLE or DONE, so the start is accepted
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; start = 1'b1;
    sb.push_back(model(ia, ib, ic));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no_done required=done t=%0t", $time);
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sum"},  32'(sum),  0);
    chk({tag, "_cout"}, 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"},  32'(ovf),  0);
`endif
    sb.delete();
    hold = '{sum: '0, co: 1'b0, ov: 1'b0};
    busy_run = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: result check on done, hold check while busy
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_run++;
        chk("hold_sum", 32'(sum), 32'(hold.sum));
        chk("hold_cout", 32'(cout), 32'(hold.co));
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=done required=no_done t=%0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.ov));
`endif
          chk("busy_len", 32'(busy_run), W);
          chk("done_single", 32'(prev_done), 0);
          hold = e;
        end
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    hold = '{sum: '0, co: 1'b0, ov: 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    rst = 1'b0;
    @(negedge clk);

    op(8'h0F, 8'h01, 1'b0); wait_done(); @(negedge clk);
    op(8'hFF, 8'h01, 1'b0); wait_done();
    op(8'h7F, 8'h01, 1'b0); wait_done(); @(negedge clk);

    // Start during RUN must be ignored
    op(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: accepted in the DONE cycle
    op(8'h00, 8'h00, 1'b1); wait_done();

    @(negedge clk);
    async_reset_check("mid_rst");

    // Abort in flight
    @(negedge clk);
    op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    async_reset_check("abort");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    op(8'h01, 8'h01, 1'b0); wait_done();

    for (int i = 0; i < 40; i++) begin
      int gap;
      op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the team's FullAdder1bit cell, which has ports w0, w1, cin, y and cout.
- A single FullAdder1bit instance is time-multiplexed one bit per clock, LSB first.
- A registered carry closes the loop between bit steps.
- The block is the sequencing stage that feeds the 1-bit cell and collects its outputs. It gives a small-area alternative to a ripple adder, for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, default 8: operand and sum width in bits. Legal range 2..32.
- CNT_W, default 5: bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A. Captured on an accepted start.
- b  input  WIDTH  operand B. Captured on an accepted start.
- cin  input  1  carry-in. Captured on an accepted start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when sum and cout update.
- sum  output  WIDTH  result register. Holds the last completed result.
- cout  output  1  carry out of the MSB of the last completed result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all shift registers, carry, counter = 0.
  - busy=0, done=0, sum=0, cout=0.
  - Reset mid-RUN aborts the operation. No done pulse; sum and cout read 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge E0: a_sh<=a, b_sh<=b, carry<=cin, s_sh<=0, cnt<=0, state<=RUN, busy<=1.
  - start=0: remain in IDLE.
- RUN, at each edge:
  - Cell inputs: w0=a_sh[0], w1=b_sh[0], cin=carry.
  - s_sh <= {y, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with 0 fill; carry <= cout of the cell; cnt <= cnt+1.
  - The start input is ignored; the operands in flight are unaffected.
- RUN, on the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - sum <= {y, s_sh[WIDTH-1:1]}; cout output <= cell cout.
  - state<=DONE, done<=1, busy<=0.
- Latency and timing:
  - busy is high for exactly WIDTH cycles.
  - done is high for exactly the one cycle after E_WIDTH.
  - Total latency from start to done is WIDTH+1 edges.
- DONE (one cycle):
  - done<=0 next edge.
  - If start=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation, no gap cycle) and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- sum and cout change only at E_WIDTH of a completed operation or on reset. They stay stable throughout the next operation's RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation.
- a, b and cin may change freely after acceptance.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered and updated at the same edge as sum.
  - ovf = (carry into the MSB) XOR (carry out of the MSB), i.e. signed two's-complement overflow. The carry into the MSB is the carry register value during the final RUN cycle.
  - Reset value 0. Holds until the next completion.
- Undefined:
  - No ovf port and no associated logic; the remaining behaviour is identical.

Test Plan (WIDTH=8):
- Reset: assert rst asynchronously mid-cycle -> busy=0, done=0, sum=8'h00, cout=0 immediately, without waiting for a clock edge.
- Basic add: a=8'h0F, b=8'h01, cin=0, start pulse -> busy high 8 cycles, then done pulse 1 cycle, sum=8'h10, cout=0.
- Carry out: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0 (if SERIAL_ADDER_OVF_EN). Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Busy and hold:
  - a=8'h12, b=8'h34, cin=1; second start with a=8'hFF, b=8'hFF at RUN cycle 3 is ignored -> sum=8'h47, cout=0.
  - During the run, sum still shows the previous result.
- Back-to-back: start held high in the DONE cycle with a=8'h00, b=8'h00, cin=1 -> new RUN begins with no IDLE cycle; 8 cycles later sum=8'h01, cout=0.
- Abort: start a=8'hAA, b=8'h55; assert rst at RUN cycle 4 -> no done pulse, sum=8'h00. After release, the next start with a=8'h01, b=8'h01 gives sum=8'h02.
